// File: rtl/mux_nt1_pipe.sv
// mux_nt1_pipe: N-to-1 channel multiplexer with a single registered output
// stage and valid/ready handshaking. MODE 0 picks the channel from s;
// MODE 1 round-robins among the channels presenting valid data.
module mux_nt1_pipe #(
  parameter int WIDTH = 32,
  parameter int CH    = 4,
  parameter int MODE  = 0,
  localparam int SELW = (CH > 2) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*WIDTH-1:0]   I,
  input  logic [CH-1:0]         in_valid,
  output logic [CH-1:0]         in_ready,
  input  logic [SELW-1:0]       s,
  output logic [WIDTH-1:0]      o,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [SELW-1:0]       o_ch
);

  // Output register stage and round-robin pointer.
  logic [WIDTH-1:0] o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic [SELW-1:0]  o_ch_q, o_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  // Arbitration results.
  logic             ld_s;
  logic             found_s;
  logic [SELW-1:0]  sel_idx_s;
  logic [CH-1:0]    in_ready_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             xfer_s;

  // Channel choice and combinational accept strobes; the register only
  // accepts when it is empty or being drained, and never during reset.
  always_comb begin
    int idx;
    ld_s       = (!o_valid_q | o_ready) & !rst;
    found_s    = 1'b0;
    sel_idx_s  = {SELW{1'b0}};
    in_ready_s = {CH{1'b0}};
    idx        = 0;
    if (MODE == 0) begin
      // Strobe depends only on s and ld, never on in_valid; out-of-range
      // s matches no channel so nothing is accepted.
      for (int k = 0; k < CH; k++) begin
        if (int'(s) == k) begin
          in_ready_s[k] = ld_s;
          sel_idx_s     = SELW'(k);
        end else begin
          in_ready_s[k] = in_ready_s[k];
        end
      end
    end else begin
      // Search upward from ptr+1, wrapping, for the first valid channel.
      for (int i = 1; i <= CH; i++) begin
        idx = (int'(ptr_q) + i) % CH;
        for (int k = 0; k < CH; k++) begin
          if (!found_s && (k == idx) && in_valid[k]) begin
            found_s   = 1'b1;
            sel_idx_s = SELW'(k);
          end else begin
            found_s   = found_s;
          end
        end
      end
      for (int k = 0; k < CH; k++) begin
        if (found_s && (int'(sel_idx_s) == k)) begin
          in_ready_s[k] = ld_s;
        end else begin
          in_ready_s[k] = 1'b0;
        end
      end
    end
  end

  // Data mux for the chosen channel and transfer detection.
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    for (int k = 0; k < CH; k++) begin
      if (int'(sel_idx_s) == k) begin
        sel_data_s = I[k*WIDTH +: WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
    xfer_s = |(in_valid & in_ready_s);
  end

  // Next-state: load on transfer, clear valid on a pure drain, else hold.
  always_comb begin
    o_d       = o_q;
    o_valid_d = o_valid_q;
    o_ch_d    = o_ch_q;
    ptr_d     = ptr_q;
    if (xfer_s) begin
      o_d       = sel_data_s;
      o_ch_d    = sel_idx_s;
      o_valid_d = 1'b1;
      ptr_d     = sel_idx_s;
    end else if (o_ready) begin
      o_valid_d = 1'b0;
    end else begin
      o_valid_d = o_valid_q;
    end
  end

  // State registers; reset leaves ptr at CH-1 so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q       <= {WIDTH{1'b0}};
      o_valid_q <= 1'b0;
      o_ch_q    <= {SELW{1'b0}};
      ptr_q     <= SELW'(CH - 1);
    end else begin
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      o_ch_q    <= o_ch_d;
      ptr_q     <= ptr_d;
    end
  end

  assign in_ready = in_ready_s;
  assign o        = o_q;
  assign o_valid  = o_valid_q;
  assign o_ch     = o_ch_q;

endmodule

// File: tb/tb_mux_nt1_pipe.sv
// Self-checking bench for mux_nt1_pipe: explicit-select, round-robin and
// CH=3 out-of-range instances, with scoreboard queues for delivered words.
module tb_mux_nt1_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] data;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  // Instance A: MODE 0, CH 4
  logic [127:0] a_I;
  logic [3:0]   a_iv, a_ir;
  logic [1:0]   a_s, a_och;
  logic [31:0]  a_o;
  logic         a_ov, a_ordy;
  // Instance B: MODE 1, CH 4
  logic [127:0] b_I;
  logic [3:0]   b_iv, b_ir;
  logic [1:0]   b_s, b_och;
  logic [31:0]  b_o;
  logic         b_ov, b_ordy;
  // Instance C: MODE 0, CH 3
  logic [95:0]  c_I;
  logic [2:0]   c_iv, c_ir;
  logic [1:0]   c_s, c_och;
  logic [31:0]  c_o;
  logic         c_ov, c_ordy;

  mux_nt1_pipe #(.WIDTH(32), .CH(4), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .I(a_I), .in_valid(a_iv), .in_ready(a_ir), .s(a_s),
    .o(a_o), .o_valid(a_ov), .o_ready(a_ordy), .o_ch(a_och));
  mux_nt1_pipe #(.WIDTH(32), .CH(4), .MODE(1)) u_b (
    .clk(clk), .rst(rst), .I(b_I), .in_valid(b_iv), .in_ready(b_ir), .s(b_s),
    .o(b_o), .o_valid(b_ov), .o_ready(b_ordy), .o_ch(b_och));
  mux_nt1_pipe #(.WIDTH(32), .CH(3), .MODE(0)) u_c (
    .clk(clk), .rst(rst), .I(c_I), .in_valid(c_iv), .in_ready(c_ir), .s(c_s),
    .o(c_o), .o_valid(c_ov), .o_ready(c_ordy), .o_ch(c_och));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Scoreboard: pop and compare whenever a word leaves a DUT.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_ov && a_ordy) begin
      if (qa.size() == 0) check_eq("a_sb_empty", 64'd1, 64'd0);
      else begin
        e = qa.pop_front();
        check_eq("a_sb_o", 64'(a_o), 64'(e.data));
        check_eq("a_sb_ch", 64'(a_och), 64'(e.ch));
      end
    end
    if (!rst && b_ov && b_ordy) begin
      if (qb.size() == 0) check_eq("b_sb_empty", 64'd1, 64'd0);
      else begin
        e = qb.pop_front();
        check_eq("b_sb_o", 64'(b_o), 64'(e.data));
        check_eq("b_sb_ch", 64'(b_och), 64'(e.ch));
      end
    end
  end

  initial begin
    int exp_rr[9];
    logic [31:0] w;
    exp_rr = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
    rst = 1'b1;
    a_I = '0; a_iv = '0; a_s = '0; a_ordy = 1'b0;
    b_I = '0; b_iv = '0; b_s = '0; b_ordy = 1'b0;
    c_I = '0; c_iv = '0; c_s = '0; c_ordy = 1'b0;

    // Reset for 2 clk; strobes must stay low during reset
    samp();
    check_eq("rst_ir_a", 64'(a_ir), 64'd0);
    check_eq("rst_ir_b", 64'(b_ir), 64'd0);
    check_eq("rst_ir_c", 64'(c_ir), 64'd0);
    tick();
    tick(); rst = 1'b0; a_iv = 4'b0000;
    samp();
    check_eq("idle_o", 64'(a_o), 64'd0);
    check_eq("idle_ov", 64'(a_ov), 64'd0);
    check_eq("idle_och", 64'(a_och), 64'd0);

    // MODE 0 select channel 2
    tick(); a_s = 2'd2; a_I = {32'h3333_0003, 32'hDEAD_BEEF, 32'h2222_0001, 32'h1111_0000};
    a_iv = 4'b0100; a_ordy = 1'b1;
    samp();
    check_eq("sel_ir", 64'(a_ir), 64'h4);
    qa.push_back('{2'd2, 32'hDEAD_BEEF});
    tick(); a_iv = 4'b0000;
    samp();
    check_eq("sel_o", 64'(a_o), 64'hDEAD_BEEF);
    check_eq("sel_och", 64'(a_och), 64'd2);
    check_eq("sel_ov", 64'(a_ov), 64'd1);
    tick();
    samp();
    check_eq("drain_ov", 64'(a_ov), 64'd0);

    // Stall hold
    tick(); a_s = 2'd0; a_I[31:0] = 32'h1111_1111; a_iv = 4'b0001; a_ordy = 1'b0;
    samp();
    check_eq("stall_ld_ir", 64'(a_ir), 64'h1);
    qa.push_back('{2'd0, 32'h1111_1111});
    for (int j = 0; j < 3; j++) begin
      tick(); a_s = 2'(j + 1); a_I = {4{$urandom()}}; a_iv = 4'b1111;
      samp();
      check_eq("stall_ir", 64'(a_ir), 64'd0);
      check_eq("stall_o", 64'(a_o), 64'h1111_1111);
      check_eq("stall_ov", 64'(a_ov), 64'd1);
      check_eq("stall_och", 64'(a_och), 64'd0);
    end
    tick(); a_iv = 4'b0000; a_ordy = 1'b1;
    samp();
    tick();
    samp();
    check_eq("unstall_ov", 64'(a_ov), 64'd0);
    check_eq("unstall_o_keep", 64'(a_o), 64'h1111_1111);

    // Back-to-back: 8 words on channel 1
    for (int k = 0; k < 8; k++) begin
      tick(); a_s = 2'd1; a_iv = 4'b0010; w = 32'hB000_0000 + 32'(k); a_I[63:32] = w; a_ordy = 1'b1;
      samp();
      check_eq("b2b_ir", 64'(a_ir), 64'h2);
      qa.push_back('{2'd1, w});
      if (k > 0) check_eq("b2b_ov", 64'(a_ov), 64'd1);
    end
    tick(); a_iv = 4'b0000;
    samp();
    check_eq("b2b_last_ov", 64'(a_ov), 64'd1);
    tick();
    samp();
    check_eq("b2b_end_ov", 64'(a_ov), 64'd0);

    // Reset during a stall discards the held word
    tick(); a_s = 2'd3; a_I[127:96] = 32'hCAFE_F00D; a_iv = 4'b1000; a_ordy = 1'b0;
    samp();
    check_eq("rs_ld_ir", 64'(a_ir), 64'h8);
    tick(); a_iv = 4'b0000;
    samp();
    check_eq("rs_stall_ov", 64'(a_ov), 64'd1);
    tick(); rst = 1'b1;
    samp();
    check_eq("rs_ir", 64'(a_ir), 64'd0);
    tick(); rst = 1'b0; a_ordy = 1'b1; a_s = 2'd0; a_I[31:0] = 32'h0000_0077; a_iv = 4'b0001;
    samp();
    check_eq("rs_ov", 64'(a_ov), 64'd0);
    check_eq("rs_o", 64'(a_o), 64'd0);
    check_eq("first_ir", 64'(a_ir), 64'h1);
    qa.push_back('{2'd0, 32'h0000_0077});
    tick(); a_iv = 4'b0000;
    samp();
    check_eq("first_o", 64'(a_o), 64'h77);
    tick();

    // MODE 1 round-robin from reset
    rst = 1'b1;
    samp();
    tick(); rst = 1'b0; b_ordy = 1'b1;
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (cyc > 0) tick();
      b_iv = (cyc < 5) ? 4'b1111 : 4'b1010;
      for (int k = 0; k < 4; k++) b_I[k*32 +: 32] = {4'hC, 4'(k), 24'(cyc)};
      samp();
      check_eq("rr_ir", 64'(b_ir), 64'(4'b0001 << exp_rr[cyc]));
      qb.push_back('{2'(exp_rr[cyc]), {4'hC, 4'(exp_rr[cyc]), 24'(cyc)}});
    end
    tick(); b_iv = 4'b0000;
    samp();
    check_eq("rr_none_ir", 64'(b_ir), 64'd0);
    tick();
    // MODE 1 stall: ptr holds at 3, so channel 2 wins then pointer moves to 2
    tick(); b_iv = 4'b0100; b_ordy = 1'b0; b_I[95:64] = 32'h5555_0002;
    samp();
    check_eq("rr_st_ir", 64'(b_ir), 64'h4);
    qb.push_back('{2'd2, 32'h5555_0002});
    tick(); b_iv = 4'b1111;
    samp();
    check_eq("rr_stall_ir", 64'(b_ir), 64'd0);
    check_eq("rr_stall_och", 64'(b_och), 64'd2);
    tick(); b_iv = 4'b0000; b_ordy = 1'b1;
    samp();
    tick(); b_iv = 4'b1111; b_I[127:96] = 32'h6666_0003;
    samp();
    check_eq("rr_after_ir", 64'(b_ir), 64'h8);
    qb.push_back('{2'd3, 32'h6666_0003});
    tick(); b_iv = 4'b0000;
    samp();
    tick();

    // CH=3 boundary: s=3 out of range
    tick(); c_s = 2'd3; c_iv = 3'b111; c_ordy = 1'b1; c_I = {32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
    samp();
    check_eq("oor_ir", 64'(c_ir), 64'd0);
    tick();
    samp();
    check_eq("oor_ov", 64'(c_ov), 64'd0);
    tick(); c_s = 2'd2;
    samp();
    check_eq("c_sel2_ir", 64'(c_ir), 64'h4);
    tick(); c_iv = 3'b000;
    samp();
    check_eq("c_sel2_ov", 64'(c_ov), 64'd1);
    check_eq("c_sel2_o", 64'(c_o), 64'hC2C2_C2C2);
    check_eq("c_sel2_och", 64'(c_och), 64'd2);
    tick();
    samp();

    check_eq("a_sb_left", 64'(qa.size()), 64'd0);
    check_eq("b_sb_left", 64'(qb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
